// File: rtl/updown_counter_param_pkg.sv
// counter_pkg: shared types and width helper for updown_counter_param.
package counter_pkg;

  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  localparam int ARITH_GUARD_BITS = 1;

  // Width of the guarded arithmetic used for overflow decisions.
  function automatic int arith_width(input int width);
    return width + ARITH_GUARD_BITS;
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param; presc exists only with
// COUNTER_PRESCALE_EN.
interface updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE_W = 8
`endif
) ();
  import counter_pkg::*;

  logic              en;
  logic              ld;
  logic [WIDTH-1:0]  ld_val;
  logic              dir;
  logic [STEP_W-1:0] step;
  mode_e             mode;
  logic [WIDTH-1:0]  lim;
  logic [WIDTH-1:0]  count;
  logic              at_lim;
  logic              at_zero;
  logic              tc;
  logic              ovf;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc;

  modport master (output en, ld, ld_val, dir, step, mode, lim, presc,
                  input  count, at_lim, at_zero, tc, ovf);
  modport slave  (input  en, ld, ld_val, dir, step, mode, lim, presc,
                  output count, at_lim, at_zero, tc, ovf);
`else
  modport master (output en, ld, ld_val, dir, step, mode, lim,
                  input  count, at_lim, at_zero, tc, ovf);
  modport slave  (input  en, ld, ld_val, dir, step, mode, lim,
                  output count, at_lim, at_zero, tc, ovf);
`endif

endinterface

// File: rtl/updown_counter_param_prescaler.sv
// counter_prescaler: divides en cycles by presc+1; built only with
// COUNTER_PRESCALE_EN.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_r;

  // The step happens in the same en cycle the phase matches presc.
  assign tick = en && (cnt_r == presc);

  // Phase counter: cleared by reset/load, restarts after every tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (tick) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
`endif

// File: rtl/updown_counter_param.sv
// updown_counter_param: up/down counter over 0..lim with step, wrap/saturate,
// terminal pulse and sticky overflow. Optional prescaler: COUNTER_PRESCALE_EN.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE_W = 8
`endif
) (
  input logic                  clk,
  input logic                  rst,
  updown_counter_param_if.slave bus
);

  localparam int AW = arith_width(WIDTH);
  localparam int MW = (STEP_W > AW) ? STEP_W : AW;

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_nxt_s;
  logic             tick_s;
  logic             step_go_s;
  logic [MW-1:0]    step_m_s;
  logic [MW-1:0]    lim_m_s;
  logic [WIDTH-1:0] s_s;
  logic [AW-1:0]    up_sum_x_s;
  logic [WIDTH-1:0] one_s;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.ld),
    .en    (bus.en),
    .presc (bus.presc),
    .tick  (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  assign one_s      = {{(WIDTH-1){1'b0}}, 1'b1};
  assign step_m_s   = MW'(bus.step);
  assign lim_m_s    = MW'(bus.lim);
  assign s_s        = (step_m_s < lim_m_s) ? step_m_s[WIDTH-1:0] : bus.lim;
  assign up_sum_x_s = {1'b0, count_r} + {1'b0, s_s};
  assign step_go_s  = bus.en && tick_s && (bus.step != {STEP_W{1'b0}});

  // Next-state selection. Overflow decisions use the guard bit; every
  // selected result lies in 0..lim, so WIDTH-bit modular sums are exact.
  always_comb begin
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    ovf_nxt_s   = ovf_r;
    if (bus.ld) begin
      count_nxt_s = (bus.ld_val < bus.lim) ? bus.ld_val : bus.lim;
      ovf_nxt_s   = 1'b0;
    end else if (step_go_s) begin
      if (count_r > bus.lim) begin
        count_nxt_s = (bus.mode == MODE_SAT) ? bus.lim : {WIDTH{1'b0}};
        tc_nxt_s    = 1'b1;
        ovf_nxt_s   = 1'b1;
      end else if (bus.lim == {WIDTH{1'b0}}) begin
        count_nxt_s = {WIDTH{1'b0}};
        tc_nxt_s    = 1'b1;
        ovf_nxt_s   = 1'b1;
      end else if (bus.dir) begin
        if (up_sum_x_s <= {1'b0, bus.lim}) begin
          count_nxt_s = up_sum_x_s[WIDTH-1:0];
        end else begin
          count_nxt_s = (bus.mode == MODE_SAT) ? bus.lim
                                               : (count_r + s_s - bus.lim - one_s);
          tc_nxt_s    = 1'b1;
          ovf_nxt_s   = 1'b1;
        end
      end else begin
        if (count_r >= s_s) begin
          count_nxt_s = count_r - s_s;
        end else begin
          count_nxt_s = (bus.mode == MODE_SAT) ? {WIDTH{1'b0}}
                                               : (count_r + bus.lim + one_s - s_s);
          tc_nxt_s    = 1'b1;
          ovf_nxt_s   = 1'b1;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count, terminal pulse and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign bus.count   = count_r;
  assign bus.tc      = tc_r;
  assign bus.ovf     = ovf_r;
  assign bus.at_lim  = (count_r == bus.lim);
  assign bus.at_zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param; the prescale scenario runs only
// when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_param;
  import counter_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  typedef struct packed {
    logic              rst;
    logic              ld;
    logic              en;
    logic              dir;
    mode_e             mode;
    logic [WIDTH-1:0]  ld_val;
    logic [WIDTH-1:0]  lim;
    logic [STEP_W-1:0] step;
  } stim_t;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  updown_counter_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  updown_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic apply(input stim_t s);
    rst        = s.rst;
    bus.ld     = s.ld;
    bus.en     = s.en;
    bus.dir    = s.dir;
    bus.mode   = s.mode;
    bus.ld_val = s.ld_val;
    bus.lim    = s.lim;
    bus.step   = s.step;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b1, 1'b1, 1'b1, 1'b1, MODE_WRAP, 8'd55, 8'd200, 4'd1}); ex.push_back('{8'd0, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b1, 1'b1, 1'b1, MODE_WRAP, 8'd200, 8'd150, 4'd1}); ex.push_back('{8'd150, 1'b0, 1'b0});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL reset[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_up();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd8, 8'd9, 4'd3}); ex.push_back('{8'd8, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd8, 8'd9, 4'd3}); ex.push_back('{8'd1, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 8'd8, 8'd9, 4'd3}); ex.push_back('{8'd1, 1'b0, 1'b1});
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd1, 8'd9, 4'd3}); ex.push_back('{8'd1, 1'b0, 1'b0});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL wrap_up[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_sat_down();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b0, MODE_SAT, 8'd2, 8'd255, 4'd5}); ex.push_back('{8'd2, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT, 8'd2, 8'd255, 4'd5}); ex.push_back('{8'd0, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT, 8'd2, 8'd255, 4'd5}); ex.push_back('{8'd0, 1'b1, 1'b1});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL sat_down[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_priority_hold();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b1, 1'b1, MODE_WRAP, 8'd7, 8'd255, 4'd3}); ex.push_back('{8'd7, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++) begin
      st.push_back('{1'b0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 8'd7, 8'd255, 4'd3}); ex.push_back('{8'd7, 1'b0, 1'b0});
    end
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd7, 8'd255, 4'd0}); ex.push_back('{8'd7, 1'b0, 1'b0});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL priority_hold[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_lim_lowered();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_SAT, 8'd100, 8'd255, 4'd1});  ex.push_back('{8'd100, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_SAT, 8'd100, 8'd50, 4'd1});   ex.push_back('{8'd50, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd100, 8'd255, 4'd1}); ex.push_back('{8'd100, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd100, 8'd50, 4'd1});  ex.push_back('{8'd0, 1'b1, 1'b1});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL lim_lowered[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_patterns();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd5, 8'd20, 4'd4}); ex.push_back('{8'd5, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd20, 4'd4}); ex.push_back('{8'd9, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd20, 4'd4}); ex.push_back('{8'd13, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd20, 4'd4}); ex.push_back('{8'd17, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd20, 4'd4}); ex.push_back('{8'd0, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd5, 8'd20, 4'd6}); ex.push_back('{8'd15, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd5, 8'd20, 4'd6}); ex.push_back('{8'd9, 1'b0, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd3, 4'd15}); ex.push_back('{8'd0, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd3, 4'd15}); ex.push_back('{8'd3, 1'b0, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 8'd3, 4'd15}); ex.push_back('{8'd2, 1'b1, 1'b1});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL wrap_patterns[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_sat_up_hold();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_SAT, 8'd9, 8'd10, 4'd2}); ex.push_back('{8'd9, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_SAT, 8'd9, 8'd10, 4'd2}); ex.push_back('{8'd10, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_SAT, 8'd9, 8'd10, 4'd2}); ex.push_back('{8'd10, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT, 8'd9, 8'd10, 4'd2}); ex.push_back('{8'd8, 1'b0, 1'b1});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL sat_up_hold[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_lim_zero();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd33, 8'd0, 4'd1}); ex.push_back('{8'd0, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd33, 8'd0, 4'd1}); ex.push_back('{8'd0, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT, 8'd33, 8'd0, 4'd1});  ex.push_back('{8'd0, 1'b1, 1'b1});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b0, MODE_SAT, 8'd33, 8'd0, 4'd0});  ex.push_back('{8'd0, 1'b0, 1'b1});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL lim_zero[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd250, 8'd255, 4'd4}); ex.push_back('{8'd250, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd250, 8'd255, 4'd4}); ex.push_back('{8'd254, 1'b0, 1'b0});
    st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd250, 8'd255, 4'd4}); ex.push_back('{8'd2, 1'b1, 1'b1});
    st.push_back('{1'b1, 1'b1, 1'b1, 1'b1, MODE_WRAP, 8'd250, 8'd255, 4'd4}); ex.push_back('{8'd0, 1'b0, 1'b0});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL back_to_back[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    logic [WIDTH-1:0] seq_a [6];
    logic [WIDTH-1:0] seq_b [4];
    seq_a = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    seq_b = '{8'd10, 8'd10, 8'd10, 8'd11};
    bus.presc = 8'd3;
    st.push_back('{1'b0, 1'b1, 1'b0, 1'b1, MODE_WRAP, 8'd0, 8'd255, 4'd1}); ex.push_back('{8'd0, 1'b0, 1'b0});
    foreach (seq_a[k]) begin
      st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd0, 8'd255, 4'd1}); ex.push_back('{seq_a[k], 1'b0, 1'b0});
    end
    st.push_back('{1'b0, 1'b1, 1'b1, 1'b1, MODE_WRAP, 8'd10, 8'd255, 4'd1}); ex.push_back('{8'd10, 1'b0, 1'b0});
    foreach (seq_b[k]) begin
      st.push_back('{1'b0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd10, 8'd255, 4'd1}); ex.push_back('{seq_b[k], 1'b0, 1'b0});
    end
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.tc !== e.tc || bus.ovf !== e.ovf ||
          bus.at_lim !== (e.count == st[i].lim) || bus.at_zero !== (e.count == 8'd0))
        $display("FAIL prescale[%0d]: got count=%0d tc=%b ovf=%b at_lim=%b at_zero=%b, want count=%0d tc=%b ovf=%b",
                 i, bus.count, bus.tc, bus.ovf, bus.at_lim, bus.at_zero, e.count, e.tc, e.ovf);
      else n_pass++;
    end
    bus.presc = 8'd0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    bus.ld     = 1'b0;
    bus.en     = 1'b0;
    bus.dir    = 1'b1;
    bus.mode   = MODE_WRAP;
    bus.ld_val = 8'd0;
    bus.lim    = 8'd255;
    bus.step   = 4'd1;
`ifdef COUNTER_PRESCALE_EN
    bus.presc  = 8'd0;
`endif
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority_hold();
    test_lim_lowered();
    test_wrap_patterns();
    test_sat_up_hold();
    test_lim_zero();
    test_back_to_back();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
